// File: rtl/key_expand_ctrl_if.sv
// Handshake, read port and optional round-key stream of key_expand_ctrl.
// KEYEXP_RK_STREAM_EN adds the rk_valid/rk_round/rk_out stream signals.
interface key_expand_ctrl_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;
`ifdef KEYEXP_RK_STREAM_EN
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
`endif

  modport master (
    output start, key_in, rd_round,
`ifdef KEYEXP_RK_STREAM_EN
    input  rk_valid, rk_round, rk_out,
`endif
    input  busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, key_in, rd_round,
`ifdef KEYEXP_RK_STREAM_EN
    output rk_valid, rk_round, rk_out,
`endif
    output busy, done, keys_valid, rd_key
  );
endinterface

// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion controller: one schedule word per cycle, 44-word store.
// Define KEYEXP_RK_STREAM_EN to stream each completed round key on rk_*.
module key_expand_ctrl (
  input logic             clk,
  input logic             rst,
  key_expand_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FIN    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic        kv_q, kv_d;
  logic [31:0] w_q [44];
  logic [31:0] w_d [44];

  logic        gen_ok;
  logic [5:0]  idx_m1, idx_m4;
  logic [31:0] prev_w, back_w, t_w, new_w;
  logic [5:0]  rd_idx;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31;
    logic [7:0] x62, x63, x126, x127, inv;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x7   = gmul(x6, x);
    x14  = gmul(x7, x7);
    x15  = gmul(x14, x);
    x30  = gmul(x15, x15);
    x31  = gmul(x30, x);
    x62  = gmul(x31, x31);
    x63  = gmul(x62, x);
    x126 = gmul(x63, x63);
    x127 = gmul(x126, x);
    inv  = gmul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    unique case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Combinational next-word generator from w[i-1], w[i-4] and i
  always_comb begin
    gen_ok = (i_q >= 6'd4) && (i_q <= 6'd43);
    idx_m1 = gen_ok ? i_q - 6'd1 : 6'd0;
    idx_m4 = gen_ok ? i_q - 6'd4 : 6'd0;
    prev_w = w_q[idx_m1];
    back_w = w_q[idx_m4];
    t_w    = prev_w;
    if (i_q[1:0] == 2'b00)
      t_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon(i_q[5:2]), 24'h0};
    new_w  = back_w ^ t_w;
  end

  // FSM next state, word store and keys_valid update
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    kv_d    = kv_q;
    w_d     = w_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          w_d[0]  = bus.key_in[127:96];
          w_d[1]  = bus.key_in[95:64];
          w_d[2]  = bus.key_in[63:32];
          w_d[3]  = bus.key_in[31:0];
          i_d     = 6'd4;
          kv_d    = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        w_d[i_q] = new_w;
        i_d      = i_q + 6'd1;
        if (i_q == 6'd43) begin
          kv_d    = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, index, flag and word registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 6'd0;
      kv_q    <= 1'b0;
      w_q     <= '{default: 32'h0};
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      kv_q    <= kv_d;
      w_q     <= w_d;
    end
  end

  // Status decodes and combinational read port
  always_comb begin
    rd_idx          = {bus.rd_round, 2'b00};
    bus.busy        = (state_q == EXPAND);
    bus.done        = (state_q == FIN);
    bus.keys_valid  = kv_q;
    bus.rd_key      = 128'h0;
    if (kv_q && (bus.rd_round <= 4'd10))
      bus.rd_key = {w_q[rd_idx], w_q[rd_idx + 6'd1],
                    w_q[rd_idx + 6'd2], w_q[rd_idx + 6'd3]};
  end

`ifdef KEYEXP_RK_STREAM_EN
  logic         rk_valid_q, rk_valid_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic [5:0]   rk_base;

  // Capture a round key as its last word is written
  always_comb begin
    rk_base    = gen_ok ? {i_q[5:2], 2'b00} : 6'd0;
    rk_valid_d = (state_q == EXPAND) && (i_q[1:0] == 2'b11);
    rk_round_d = rk_round_q;
    rk_out_d   = rk_out_q;
    if (rk_valid_d) begin
      rk_round_d = i_q[5:2];
      rk_out_d   = {w_q[rk_base], w_q[rk_base + 6'd1],
                    w_q[rk_base + 6'd2], new_w};
    end
  end

  // Stream output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_valid_q <= 1'b0;
      rk_round_q <= 4'd0;
      rk_out_q   <= 128'h0;
    end else begin
      rk_valid_q <= rk_valid_d;
      rk_round_q <= rk_round_d;
      rk_out_q   <= rk_out_d;
    end
  end

  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_round = rk_round_q;
  assign bus.rk_out   = rk_out_q;
`endif
endmodule

// File: tb/tb_key_expand_ctrl.sv
// Testbench for key_expand_ctrl: known-answer table, random keys vs model,
// held start, reset abort; stream checks when KEYEXP_RK_STREAM_EN is set.
module tb_key_expand_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_expand_ctrl_if bus ();

  key_expand_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb [256];
  logic [127:0] mdl [11];

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rd;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [11];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    logic [7:0] r;
    r = (v << s) | (v >> (8 - s));
    return r;
  endfunction

  // S-box table from the generator-3 walk of GF(2^8)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Pulse start for key k and check every cycle through the done pulse
  task automatic run_exp(input logic [127:0] k);
    compute_model(k);
    @(negedge clk);
    bus.key_in = k;
    bus.start  = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 41; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start  = 1'b0;
        bus.key_in = ~k;
      end
      check("busy", bus.busy, n <= 40);
      check("done", bus.done, n == 41);
      check("keys_valid", bus.keys_valid, n == 41);
`ifdef KEYEXP_RK_STREAM_EN
      check("rk_valid", bus.rk_valid, (n >= 5) && ((n - 1) % 4 == 0));
      if (bus.rk_valid) begin
        check("rk_round", bus.rk_round, (n - 1) / 4);
        check("rk_out", bus.rk_out, mdl[(n - 1) / 4]);
      end
`endif
    end
  endtask

  task automatic read_chk(input string name, input logic [3:0] r,
                          input logic [127:0] exp);
    bus.rd_round = r;
    #1;
    check(name, bus.rd_key, exp);
  endtask

  initial begin
    logic [127:0] k, k2, last_key;
    bit have_key;
    build_sbox();

    vt[0]  = '{KEY_A, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vt[1]  = '{KEY_A, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[2]  = '{KEY_A, 4'd0,  KEY_A};
    vt[3]  = '{KEY_A, 4'd11, 128'h0};
    vt[4]  = '{KEY_A, 4'd12, 128'h0};
    vt[5]  = '{KEY_A, 4'd13, 128'h0};
    vt[6]  = '{KEY_A, 4'd14, 128'h0};
    vt[7]  = '{KEY_A, 4'd15, 128'h0};
    vt[8]  = '{128'h0, 4'd1,  128'h62636363626363636263636362636363};
    vt[9]  = '{128'h0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vt[10] = '{128'h0, 4'd0,  128'h0};

    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.key_in   = KEY_A;
    bus.rd_round = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_kv", bus.keys_valid, 1'b0);
    read_chk("rst_rd0", 4'd0, 128'h0);

    have_key = 1'b0;
    last_key = '0;
    for (int v = 0; v < 11; v++) begin
      if (!have_key || vt[v].key != last_key) begin
        run_exp(vt[v].key);
        last_key = vt[v].key;
        have_key = 1'b1;
      end
      read_chk($sformatf("vec%0d", v), vt[v].rd, vt[v].exp);
    end

    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_exp(k);
      for (int r = 0; r <= 10; r++)
        read_chk($sformatf("rand%0d_r%0d", t, r), 4'(r), mdl[r]);
      read_chk("rand_oob", 4'($urandom_range(11, 15)), 128'h0);
    end

    k  = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.key_in = k;
    bus.start  = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 90; n++) begin
      @(negedge clk);
      if (n == 5) bus.key_in = k2;
      if (n == 60) bus.start = 1'b0;
      check("hold_busy", bus.busy, (n <= 40) || (n >= 43 && n <= 82));
      check("hold_done", bus.done, (n == 41) || (n == 83));
      check("hold_kv", bus.keys_valid, (n == 41) || (n == 42) || (n >= 83));
    end
    compute_model(k2);
    for (int r = 0; r <= 10; r++)
      read_chk($sformatf("hold_r%0d", r), 4'(r), mdl[r]);

    compute_model(KEY_A);
    @(negedge clk);
    bus.key_in = KEY_A;
    bus.start  = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_kv", bus.keys_valid, 1'b0);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 1'b0);
    end
    for (int r = 0; r < 16; r++)
      read_chk($sformatf("abort_rd%0d", r), 4'(r), 128'h0);
    run_exp(KEY_A);
    read_chk("restart_r1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_chk("restart_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_expand_ctrl.md
KEY_EXPAND_CTRL -- requirements
Module: key_expand_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clock is clk and reset is rst.
REQ-002 Ports SHALL be: clk  in  1  rising-edge clock
REQ-003 rst  in  1  synchronous active-high reset
REQ-004 start  in  1  request expansion of key_in; one-cycle pulse or level
REQ-005 key_in  in  128  AES-128 cipher key; w0=key_in[127:96] … w3=key_in[31:0]
REQ-006 busy  out  1  expansion in progress
REQ-007 done  out  1  one-cycle pulse on expansion completion
REQ-008 keys_valid  out  1  all 11 round keys stored and readable
REQ-009 rd_round  in  4  round key index for the read port, 0..10
REQ-010 rd_key  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, r=rd_round
REQ-011 rk_valid, rk_round[3:0], rk_out[127:0]  out  present only with KEYEXP_RK_STREAM_EN (REQ-028).

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, EXPAND, FIN.
REQ-013 IDLE: start=1 at an edge loads w0..w3 from key_in, sets word index i=4, clears keys_valid and enters EXPAND.
REQ-014 EXPAND: each cycle computes and stores exactly one word w[i] = w[i-4] XOR t, then increments i.
REQ-015 t = SubWord(RotWord(w[i-1])) XOR {Rcon(i/4),24'h0} when i mod 4 = 0; otherwise t = w[i-1].
REQ-016 Rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36; SubWord applies the AES S-box per byte.
REQ-017 The word generator SHALL be purely combinational from the stored w[i-1], w[i-4] and i; no pipeline stage inside the generator.
REQ-018 After w43 is written, the FSM SHALL enter FIN; FIN lasts exactly one cycle and then returns to IDLE.
REQ-019 Latency: start sampled at edge T -> busy=1 for cycles T+1..T+40 (40 cycles), done=1 during cycle T+41 only, keys_valid=1 from cycle T+41 onward.
REQ-020 busy = (state==EXPAND); done = (state==FIN); both registered-state decodes, glitch-free.
REQ-021 start SHALL be ignored in EXPAND and FIN; no queuing of a request.
REQ-022 keys_valid SHALL remain 1 until the next accepted start or reset; key_in changes while not loading have no effect.
REQ-023 rd_key is combinational from rd_round and storage; rd_key = 0 when keys_valid=0 or rd_round > 10.
REQ-024 Storage: 44 x 32-bit word registers; w0..w3 retain the loaded key for round 0 readout.

Reset
REQ-025 rst=1 at an edge SHALL force state=IDLE, i=0, busy=0, done=0, keys_valid=0 and all word registers to 0, overriding start.
REQ-026 rst asserted mid-expansion SHALL abort it; no done pulse follows, and the next start restarts from w0.
REQ-027 With KEYEXP_RK_STREAM_EN, reset SHALL also clear rk_valid, rk_round and rk_out to 0.

Configuration
REQ-028 Macro KEYEXP_RK_STREAM_EN defined: rk_valid pulses one cycle after each word with i mod 4 = 3 is stored (i=7,11,…,43), with rk_round=i/4 and rk_out = that round key; 10 pulses per expansion (rounds 1..10); round 0 is not streamed.
REQ-029 Macro undefined: the rk_* ports and their registers SHALL be absent; all other behaviour is identical.

Verification
REQ-030 key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> done exactly 41 cycles later; rd_round=1 gives a0fafe1788542cb123a339392a6c7605; rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-031 key_in=0 -> rd_round=1 gives 62636363626363636263636362636363; rd_round=10 gives b4ef5bcb3e92e21123e951cf6f8f188e; rd_round=0 gives 0.
REQ-032 start held high for 60 cycles -> exactly one expansion while busy, a second accepted at the first IDLE cycle after FIN; keys_valid drops at that accept.
REQ-033 rst pulsed at cycle T+20 of an expansion -> busy=0, keys_valid=0, no done; rd_key=0 for every rd_round; a fresh start gives the REQ-030 results.
REQ-034 After a completed expansion, rd_round=11..15 -> rd_key=0.
REQ-035 With KEYEXP_RK_STREAM_EN, run REQ-030 -> 10 rk_valid pulses, rk_round 1..10 in order, spaced 4 cycles apart; the last is in the same cycle as done, with rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
